// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for a classic five-stage MIPS-style pipeline. It
// registers the decoded control and datapath fields, detects load-use hazards
// against the instruction currently in EX, and inserts a single bubble when
// the ID instruction must wait or has been squashed. Two saturating
// performance counters track stall cycles and flushed ID instructions.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   id_valid_i               ID slot holds a real instruction
//   RegDst_i .. Jump_i       decoded 1-bit control from the ID Control unit
//   ALUOp_i                  ALU operation class
//   RS1data_i, RS2data_i     register operands (DATA_W)
//   imm_i                    sign-extended immediate (DATA_W)
//   rs_i, rt_i, rd_i         register specifiers
//   funct_i                  R-type function field
//   flush_i                  ID instruction squashed
//   stall_o                  load-use hazard, hold PC and IF/ID (combinational)
//   ex_valid_o               EX slot holds a real instruction
//   ex_*_o                   registered control and datapath fields for EX
//   stall_cnt_o, flush_cnt_o saturating performance counters (CNT_W)
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic              RegDst_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic              Branch_i,
    input  logic              Jump_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [5:0]        funct_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic              ex_RegDst_o,
    output logic              ex_ALUSrc_o,
    output logic              ex_RegWrite_o,
    output logic              ex_MemRead_o,
    output logic              ex_MemWrite_o,
    output logic              ex_MemtoReg_o,
    output logic [1:0]        ex_ALUOp_o,
    output logic [DATA_W-1:0] ex_RS1data_o,
    output logic [DATA_W-1:0] ex_RS2data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_rd_o,
    output logic [5:0]        ex_funct_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              uses_rt;
    logic              hazard;
    logic              bubble;

    logic              vld_p1;
    logic              regdst_p1;
    logic              alusrc_p1;
    logic              regwrite_p1;
    logic              memread_p1;
    logic              memwrite_p1;
    logic              memtoreg_p1;
    logic [1:0]        aluop_p1;
    logic [DATA_W-1:0] rs1data_p1;
    logic [DATA_W-1:0] rs2data_p1;
    logic [DATA_W-1:0] imm_p1;
    logic [4:0]        rs_p1;
    logic [4:0]        rt_p1;
    logic [4:0]        rd_p1;
    logic [5:0]        funct_p1;
    logic [CNT_W-1:0]  stall_cnt_p1;
    logic [CNT_W-1:0]  flush_cnt_p1;

    // ---- ID stage: hazard detection and bubble decision ----
    // rt is a source only for R-type (RegDst), stores and branches; for
    // I-type ALU ops and loads it is the destination and cannot conflict.
    assign uses_rt = RegDst_i | MemWrite_i | Branch_i;

    // A load into $zero never produces a value worth waiting for.
    assign hazard  = id_valid_i & vld_p1 & memread_p1 & (rt_p1 != 5'd0) &
                     ((rt_p1 == rs_i) | (uses_rt & (rt_p1 == rt_i)));

    assign stall_o = hazard;
    assign bubble  = hazard | flush_i | ~id_valid_i;

    // ---- ID/EX boundary ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1      <= 1'b0;
            regdst_p1   <= 1'b0;
            alusrc_p1   <= 1'b0;
            regwrite_p1 <= 1'b0;
            memread_p1  <= 1'b0;
            memwrite_p1 <= 1'b0;
            memtoreg_p1 <= 1'b0;
            aluop_p1    <= 2'b00;
            rs1data_p1  <= '0;
            rs2data_p1  <= '0;
            imm_p1      <= '0;
            rs_p1       <= 5'd0;
            rt_p1       <= 5'd0;
            rd_p1       <= 5'd0;
            funct_p1    <= 6'd0;
        end else if (bubble) begin
            // Datapath fields hold; only control is forced to a no-op.
            vld_p1      <= 1'b0;
            regdst_p1   <= 1'b0;
            alusrc_p1   <= 1'b0;
            regwrite_p1 <= 1'b0;
            memread_p1  <= 1'b0;
            memwrite_p1 <= 1'b0;
            memtoreg_p1 <= 1'b0;
            aluop_p1    <= 2'b00;
        end else begin
            // Jumps complete in ID, so EX sees them as a harmless no-op;
            // destination-select bits are meaningless without a write.
            vld_p1      <= 1'b1;
            regdst_p1   <= RegDst_i & RegWrite_i;
            memtoreg_p1 <= MemtoReg_i & RegWrite_i;
            alusrc_p1   <= ALUSrc_i & ~Jump_i;
            regwrite_p1 <= RegWrite_i & ~Jump_i;
            memread_p1  <= MemRead_i & ~Jump_i;
            memwrite_p1 <= MemWrite_i & ~Jump_i;
            aluop_p1    <= Jump_i ? 2'b00 : ALUOp_i;
            rs1data_p1  <= RS1data_i;
            rs2data_p1  <= RS2data_i;
            imm_p1      <= imm_i;
            rs_p1       <= rs_i;
            rt_p1       <= rt_i;
            rd_p1       <= rd_i;
            funct_p1    <= funct_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else begin
            if (hazard) begin
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
            end
            if (flush_i & id_valid_i) begin
                flush_cnt_p1 <= sat_inc(flush_cnt_p1);
            end
        end
    end

    assign ex_valid_o    = vld_p1;
    assign ex_RegDst_o   = regdst_p1;
    assign ex_ALUSrc_o   = alusrc_p1;
    assign ex_RegWrite_o = regwrite_p1;
    assign ex_MemRead_o  = memread_p1;
    assign ex_MemWrite_o = memwrite_p1;
    assign ex_MemtoReg_o = memtoreg_p1;
    assign ex_ALUOp_o    = aluop_p1;
    assign ex_RS1data_o  = rs1data_p1;
    assign ex_RS2data_o  = rs2data_p1;
    assign ex_imm_o      = imm_p1;
    assign ex_rs_o       = rs_p1;
    assign ex_rt_o       = rt_p1;
    assign ex_rd_o       = rd_p1;
    assign ex_funct_o    = funct_p1;
    assign stall_cnt_o   = stall_cnt_p1;
    assign flush_cnt_o   = flush_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. Each cycle the bench drives an ID
// instruction, predicts the hazard and the next EX contents from its own
// model of the EX slot, pushes the prediction to a scoreboard queue and pops
// it after the clock edge to compare with the DUT. The counter width is
// reduced so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic          RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch, Jump;
    logic [1:0]    ALUOp;
    logic [DW-1:0] RS1data, RS2data, imm;
    logic [4:0]    rs, rt, rd;
    logic [5:0]    funct;
    logic          flush;

    logic          stall_o;
    logic          ex_valid_o, ex_RegDst_o, ex_ALUSrc_o, ex_RegWrite_o;
    logic          ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o;
    logic [1:0]    ex_ALUOp_o;
    logic [DW-1:0] ex_RS1data_o, ex_RS2data_o, ex_imm_o;
    logic [4:0]    ex_rs_o, ex_rt_o, ex_rd_o;
    logic [5:0]    ex_funct_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    typedef struct {
        logic          valid, regdst, alusrc, regwrite, memread, memwrite, memtoreg;
        logic [1:0]    aluop;
        logic [DW-1:0] rs1, rs2, imm;
        logic [4:0]    rs, rt, rd;
        logic [5:0]    funct;
        logic [CW-1:0] scnt, fcnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;
    int   n_tests = 0;
    int   n_fail  = 0;

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .RegDst_i(RegDst), .ALUSrc_i(ALUSrc), .RegWrite_i(RegWrite),
        .MemRead_i(MemRead), .MemWrite_i(MemWrite), .MemtoReg_i(MemtoReg),
        .Branch_i(Branch), .Jump_i(Jump), .ALUOp_i(ALUOp),
        .RS1data_i(RS1data), .RS2data_i(RS2data), .imm_i(imm),
        .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct), .flush_i(flush),
        .stall_o(stall_o), .ex_valid_o(ex_valid_o),
        .ex_RegDst_o(ex_RegDst_o), .ex_ALUSrc_o(ex_ALUSrc_o),
        .ex_RegWrite_o(ex_RegWrite_o), .ex_MemRead_o(ex_MemRead_o),
        .ex_MemWrite_o(ex_MemWrite_o), .ex_MemtoReg_o(ex_MemtoReg_o),
        .ex_ALUOp_o(ex_ALUOp_o), .ex_RS1data_o(ex_RS1data_o),
        .ex_RS2data_o(ex_RS2data_o), .ex_imm_o(ex_imm_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
        .ex_funct_o(ex_funct_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ins(input logic v, input logic rdst, input logic asrc, input logic rw,
                           input logic mr, input logic mw, input logic m2r, input logic br,
                           input logic jp, input logic [1:0] aop, input logic [4:0] s,
                           input logic [4:0] t, input logic [4:0] d, input logic [DW-1:0] im,
                           input logic fl);
        id_valid = v;  RegDst = rdst; ALUSrc = asrc; RegWrite = rw;
        MemRead = mr;  MemWrite = mw; MemtoReg = m2r; Branch = br; Jump = jp;
        ALUOp = aop;   rs = s; rt = t; rd = d; imm = im; flush = fl;
        RS1data = $urandom; RS2data = $urandom; funct = 6'($urandom_range(0, 63));
    endtask

    // One clock: check the combinational stall, predict EX, compare after the edge.
    task automatic step();
        exp_t e;
        logic hz, ur, bub;
        #1;
        ur = RegDst || MemWrite || Branch;
        hz = 1'b0;
        if (id_valid && m.valid && m.memread && m.rt != 5'd0)
            if (m.rt == rs || (ur && m.rt == rt)) hz = 1'b1;
        chk("stall_o", stall_o, hz);
        bub = hz || flush || !id_valid;
        e = m;
        if (rst) begin
            e = '{default: '0};
        end else begin
            if (hz && e.scnt != '1) e.scnt = e.scnt + 1'b1;
            if (flush && id_valid && e.fcnt != '1) e.fcnt = e.fcnt + 1'b1;
            if (bub) begin
                e.valid = 0; e.regdst = 0; e.alusrc = 0; e.regwrite = 0;
                e.memread = 0; e.memwrite = 0; e.memtoreg = 0; e.aluop = 2'b00;
            end else begin
                e.valid    = 1;
                e.regwrite = Jump ? 1'b0 : RegWrite;
                e.regdst   = RegWrite ? RegDst : 1'b0;
                e.memtoreg = RegWrite ? MemtoReg : 1'b0;
                e.alusrc   = Jump ? 1'b0 : ALUSrc;
                e.memread  = Jump ? 1'b0 : MemRead;
                e.memwrite = Jump ? 1'b0 : MemWrite;
                e.aluop    = Jump ? 2'b00 : ALUOp;
                e.rs1 = RS1data; e.rs2 = RS2data; e.imm = imm;
                e.rs = rs; e.rt = rt; e.rd = rd; e.funct = funct;
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("ex_valid", ex_valid_o, e.valid);
        chk("ex_RegDst", ex_RegDst_o, e.regdst);
        chk("ex_ALUSrc", ex_ALUSrc_o, e.alusrc);
        chk("ex_RegWrite", ex_RegWrite_o, e.regwrite);
        chk("ex_MemRead", ex_MemRead_o, e.memread);
        chk("ex_MemWrite", ex_MemWrite_o, e.memwrite);
        chk("ex_MemtoReg", ex_MemtoReg_o, e.memtoreg);
        chk("ex_ALUOp", ex_ALUOp_o, e.aluop);
        chk("stall_cnt", stall_cnt_o, e.scnt);
        chk("flush_cnt", flush_cnt_o, e.fcnt);
        if (e.valid) begin
            chk("ex_RS1data", ex_RS1data_o, e.rs1);
            chk("ex_RS2data", ex_RS2data_o, e.rs2);
            chk("ex_imm", ex_imm_o, e.imm);
            chk("ex_rs", ex_rs_o, e.rs);
            chk("ex_rt", ex_rt_o, e.rt);
            chk("ex_rd", ex_rd_o, e.rd);
            chk("ex_funct", ex_funct_o, e.funct);
        end
        m = e;
    endtask

    task automatic nop();                                  set_ins(0,0,0,0,0,0,0,0,0,2'b00,0,0,0,0,0); step(); endtask
    task automatic addi(input logic [4:0] s, t, input logic [DW-1:0] im);
                                                           set_ins(1,0,1,1,0,0,0,0,0,2'b00,s,t,0,im,0); step(); endtask
    task automatic lw(input logic [4:0] s, t);             set_ins(1,0,1,1,1,0,1,0,0,2'b00,s,t,0,32'd16,0); step(); endtask
    task automatic add(input logic [4:0] s, t, d, input logic fl);
                                                           set_ins(1,1,0,1,0,0,0,0,0,2'b10,s,t,d,0,fl); step(); endtask
    task automatic sw(input logic [4:0] s, t);             set_ins(1,0,1,0,0,1,0,0,0,2'b00,s,t,0,32'd4,0); step(); endtask
    task automatic beq(input logic [4:0] s, t);            set_ins(1,0,0,0,0,0,0,1,0,2'b01,s,t,0,32'd3,0); step(); endtask
    // Jump with deliberately noisy control to exercise sanitising.
    task automatic jmp();                                  set_ins(1,1,1,1,1,1,1,0,1,2'b11,0,0,0,32'h40,0); step(); endtask

    initial begin
        m = '{default: '0};
        rst = 1'b1;
        set_ins(0,0,0,0,0,0,0,0,0,2'b00,0,0,0,0,0);
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;

        // First load right after reset.
        addi(5'd0, 5'd5, 32'd7);

        // Load-use on rs, then the held instruction issues.
        lw(5'd1, 5'd8);
        add(5'd8, 5'd9, 5'd10, 1'b0);
        add(5'd8, 5'd9, 5'd10, 1'b0);

        // Load into $zero, and I-type whose rt is a destination: no stall.
        lw(5'd1, 5'd0);
        add(5'd0, 5'd0, 5'd11, 1'b0);
        lw(5'd1, 5'd8);
        addi(5'd3, 5'd8, 32'hFFFF_FFFC);

        // Store and branch read rt.
        lw(5'd1, 5'd4);
        sw(5'd1, 5'd4);
        sw(5'd1, 5'd4);
        lw(5'd2, 5'd6);
        beq(5'd2, 5'd6);
        beq(5'd2, 5'd6);

        // Jump and write-disabled sanitising.
        jmp();
        set_ins(1,1,0,0,0,0,1,0,0,2'b10,5'd1,5'd2,5'd3,0,0); step();

        // Flush, flush on invalid slot, hazard plus flush together.
        add(5'd1, 5'd2, 5'd3, 1'b1);
        set_ins(0,1,0,1,0,0,0,0,0,2'b10,5'd1,5'd2,5'd3,0,1); step();
        lw(5'd1, 5'd8);
        add(5'd8, 5'd9, 5'd10, 1'b1);
        nop();

        // Drive the stall counter past saturation.
        for (int i = 0; i < 260; i++) begin
            lw(5'd1, 5'd8);
            add(5'd8, 5'd9, 5'd10, 1'b0);
        end
        // Drive the flush counter past saturation.
        for (int i = 0; i < 260; i++) add(5'd1, 5'd2, 5'd3, 1'b1);

        // Reset while a stall is pending.
        lw(5'd1, 5'd8);
        rst = 1'b1;
        add(5'd8, 5'd9, 5'd10, 1'b0);
        nop();
        rst = 1'b0;
        addi(5'd0, 5'd5, 32'd7);
        nop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of register-data and immediate paths.
REQ-002 Parameter CNT_W, default 16, width of each performance counter.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 id_valid_i  in  1  ID slot holds a real instruction.
REQ-006 RegDst_i, ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, Branch_i, Jump_i  in  1 each  decoded control from the ID-stage Control unit.
REQ-007 ALUOp_i  in  2  ALU operation class from Control.
REQ-008 RS1data_i, RS2data_i, imm_i  in  DATA_W each  register operands and sign-extended immediate.
REQ-009 rs_i, rt_i, rd_i  in  5 each  register specifiers; funct_i  in  6  R-type function field.
REQ-010 flush_i  in  1  ID instruction squashed (taken branch/jump resolved in ID).
REQ-011 stall_o  out  1  load-use hazard; PC and IF/ID must hold this cycle (combinational).
REQ-012 ex_valid_o  out  1  EX slot holds a real instruction.
REQ-013 ex_RegDst_o, ex_ALUSrc_o, ex_RegWrite_o, ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o  out  1 each; ex_ALUOp_o  out  2  registered control.
REQ-014 ex_RS1data_o, ex_RS2data_o, ex_imm_o  out  DATA_W; ex_rs_o, ex_rt_o, ex_rd_o  out  5; ex_funct_o  out  6  registered datapath fields.
REQ-015 stall_cnt_o, flush_cnt_o  out  CNT_W  saturating performance counters.

Function
REQ-016 uses_rt = RegDst_i | MemWrite_i | Branch_i; rs always treated as read.
REQ-017 hazard = id_valid_i & ex_valid_o & ex_MemRead_o & (ex_rt_o != 0) & ((ex_rt_o == rs_i) | (uses_rt & (ex_rt_o == rt_i))).
REQ-018 stall_o SHALL equal hazard, independent of flush_i; no registered delay.
REQ-019 Latency: one cycle; fields presented at edge N appear on ex_* after edge N.
REQ-020 Bubble condition = hazard | flush_i | ~id_valid_i; on bubble, next ex_valid_o and all ex_* control outputs SHALL be 0; datapath fields MAY load or hold, value don't-care.
REQ-021 Non-bubble: ex_valid_o <= 1, all fields load from inputs.
REQ-022 Sanitising on load: RegWrite_i=0 forces ex_RegDst_o=0 and ex_MemtoReg_o=0; Jump_i=1 forces ex_ALUOp_o=00, ex_ALUSrc_o=0, ex_RegWrite_o=0, ex_MemRead_o=0, ex_MemWrite_o=0.
REQ-023 Branch_i and Jump_i SHALL NOT be forwarded to EX.
REQ-024 Stall lasts exactly one cycle per load: after the bubble, ex_MemRead_o=0 so hazard deasserts unless a new load enters EX.
REQ-025 stall_cnt_o increments by 1 each cycle stall_o=1; flush_cnt_o increments each cycle flush_i=1 & id_valid_i=1; both saturate at all-ones (no wrap).
REQ-026 Simultaneous hazard and flush_i: single bubble, stall_o=1, both counters increment.
REQ-027 Priority of next-state selection: rst_i > bubble > normal load.

Reset
REQ-028 rst_i=1 at an edge SHALL clear ex_valid_o, all ex_* outputs, stall_cnt_o and flush_cnt_o to 0.
REQ-029 During rst_i, stall_o SHALL be 0 after the first reset edge (EX empty); reset mid-stall discards the bubble and any held instruction.
REQ-030 First non-bubble load is permitted on the first edge with rst_i=0.

Verification
REQ-031 Reset for 2 cycles, then addi (RegWrite=1, ALUSrc=1, rt=5, imm=7) -> next cycle ex_valid_o=1, ex_ALUSrc_o=1, ex_rt_o=5, ex_imm_o=7, counters 0.
REQ-032 lw rt=8 into EX, then ID add rs=8 rt=9 -> stall_o=1 that cycle, next cycle ex_valid_o=0, ex_RegWrite_o=0, stall_o=0, stall_cnt_o=1.
REQ-033 lw rt=0 in EX, ID reads rs=0 -> stall_o=0; lw rt=8 in EX, ID addi rs=3 rt=8 (uses_rt=0) -> stall_o=0.
REQ-034 ID sw with Jump=0 after lw rt=4, sw rt=4 -> stall_o=1; ID jump with ALUOp_i=11 -> ex_ALUOp_o=00, ex_RegWrite_o=0.
REQ-035 flush_i=1 with valid R-type in ID -> next ex_valid_o=0, all ex control 0, flush_cnt_o=1; hazard+flush together -> one bubble, both counters +1.
REQ-036 Force 65535 stall cycles then one more -> stall_cnt_o stays 0xFFFF; assert rst_i mid-stall -> all outputs 0 on next edge.
